fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width of the FIFO read port and the output stream.
REQ-002 Parameter BURST_MAX, default 16, largest burst length; CNT_W = $clog2(BURST_MAX+1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 rd_en  output  1  read request to the FIFO read port.
REQ-006 rd_data  input  DATA_WIDTH  FIFO read data, valid when rd_val=1.
REQ-007 rd_val  input  1  FIFO response, high in the cycle after an rd_en that hit a non-empty FIFO, low after an rd_en on an empty FIFO.
REQ-008 start  input  1  one-cycle burst request, sampled only in IDLE.
REQ-009 burst_len  input  CNT_W  number of words to move, sampled with start.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  one-cycle pulse at burst completion.
REQ-012 out_valid  output  1  output stream word available.
REQ-013 out_data  output  DATA_WIDTH  output stream word.
REQ-014 out_last  output  1  marks the final word of the burst, qualified by out_valid.
REQ-015 out_ready  input  1  downstream accepts the word when out_valid & out_ready.

Function
REQ-016 State machine SHALL have states IDLE, RUN, DRAIN.
REQ-017 IDLE: start=1 and burst_len!=0 -> latch len, clear req_cnt/rcv_cnt/dlv_cnt, go RUN next edge.
REQ-018 IDLE: start=1 and burst_len=0 -> stay IDLE, done=1 for the next cycle, no rd_en.
REQ-019 start in RUN or DRAIN SHALL be ignored; burst_len changes after the start edge SHALL have no effect.
REQ-020 Internal 3-entry skid buffer (occ 0..3) plus pend flag (rd_en issued last cycle, response not yet sampled).
REQ-021 rd_en SHALL be 1 iff state=RUN and rcv_cnt+pend < len and occ+pend < 3; rd_en SHALL depend on registers only, no path from out_ready or rd_val.
REQ-022 Response sampled at the edge ending the cycle after rd_en: rd_val=1 -> push rd_data, rcv_cnt+1; rd_val=0 -> word not counted, request retried.
REQ-023 rd_val=1 without a pending request SHALL be ignored.
REQ-024 out_valid = (occ!=0); out_data = oldest entry; out_last = out_valid and dlv_cnt = len-1.
REQ-025 Pop on out_valid & out_ready; dlv_cnt+1; simultaneous push and pop SHALL keep occ unchanged and preserve order.
REQ-026 RUN -> DRAIN when rcv_cnt reaches len; DRAIN -> IDLE on the edge that pops the final word, with done=1 in the following cycle.
REQ-027 Final word accepted in the same edge rcv_cnt reaches len (occ was 0 not possible; otherwise) SHALL go RUN -> IDLE directly with done.
REQ-028 Throughput: FIFO never empty and out_ready held 1 -> one word per cycle after the first.
REQ-029 Latency: start sampled at edge E0 -> rd_en high after E0 -> out_valid high after E2.
REQ-030 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 Counters are CNT_W bits wide; len<=BURST_MAX is the caller's responsibility; no wrap within a burst.

Reset
REQ-032 reset=0 SHALL immediately force state IDLE, occ=0, pend=0, counters 0, rd_en=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
REQ-033 Reset mid-burst SHALL discard buffered and in-flight words; a response arriving after release SHALL be ignored per REQ-023.

Verification
REQ-034 FIFO holds A1..A4, start, len=4, out_ready=1 -> rd_en cycles 1-4, out_data A1..A4 on consecutive cycles from cycle 3, out_last with A4, done 1 cycle later.
REQ-035 FIFO empty, start, len=2, data pushed 5 cycles later -> rd_en repeats, rd_val=0 responses not counted, exactly 2 words out, then done.
REQ-036 len=3, out_ready=0 for 10 cycles -> at most 3 reads issued, occ=3, rd_en=0, out_data stable; release -> 3 words in order, done.
REQ-037 start with burst_len=0 -> no rd_en, done pulse next cycle, busy stays 0; start during RUN ignored.
REQ-038 Async reset asserted mid-burst between edges -> all outputs 0 immediately; after release, new len=2 burst completes correctly.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: issues burst reads against a FIFO read port with a one-cycle
// response latency, buffers returned words in a 3-entry skid buffer and
// presents them as a valid/ready stream with a last marker and a done pulse.
module fifo_reader #(
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_MAX  = 16,
    localparam int CNT_W      = $clog2(BURST_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_val,
    input  logic                  start,
    input  logic [CNT_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      len;
    logic [CNT_W-1:0]      rcv_cnt, dlv_cnt;
    logic [CNT_W-1:0]      rcv_nxt, dlv_nxt;
    logic [1:0]            occ, wr_ptr, rd_ptr;
    logic                  pend;
    logic                  done_r, done_nxt;
    logic                  push, pop;
    logic [CNT_W:0]        rcv_sum;
    logic [2:0]            occ_sum;
    logic [DATA_WIDTH-1:0] mem [3];

    // A response only counts when a request was actually outstanding.
    assign push    = pend & rd_val;
    assign pop     = out_valid & out_ready;
    assign rcv_nxt = rcv_cnt + {{(CNT_W-1){1'b0}}, push};
    assign dlv_nxt = dlv_cnt + {{(CNT_W-1){1'b0}}, pop};

    // In-flight request is reserved both against the burst length and the
    // buffer space, so a returning word always has a slot. Registers only.
    assign rcv_sum = {1'b0, rcv_cnt} + {{CNT_W{1'b0}}, pend};
    assign occ_sum = {1'b0, occ} + {2'b00, pend};
    assign rd_en   = (state == RUN) && (rcv_sum < {1'b0, len}) && (occ_sum < 3'd3);

    // Data entries are not reset; the output mux forces zero when empty.
    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign out_last  = out_valid && (dlv_cnt == len - CNT_W'(1));
    assign busy      = (state != IDLE);
    assign done      = done_r;

    // Next-state and completion pulse decode.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) state_nxt = RUN;
                    else                 done_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (rcv_nxt == len) begin
                    if (dlv_nxt == len) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (dlv_nxt == len)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= done_nxt;
        end
    end

    // Burst counters, request tracking and skid-buffer occupancy/pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len     <= '0;
            rcv_cnt <= '0;
            dlv_cnt <= '0;
            pend    <= 1'b0;
            occ     <= 2'd0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
        end else begin
            if (state == IDLE) begin
                if (start && (burst_len != '0)) begin
                    len     <= burst_len;
                    rcv_cnt <= '0;
                    dlv_cnt <= '0;
                end
            end else begin
                rcv_cnt <= rcv_nxt;
                dlv_cnt <= dlv_nxt;
            end
            pend <= rd_en;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (push) wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            if (pop)  rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
        end
    end

    // Skid-buffer storage; written on every accepted response.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rd_data;
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: behavioural FIFO read port, scoreboard of
// expected stream words, and directed bursts covering latency, empty-FIFO
// retries, backpressure, zero-length bursts and asynchronous reset.
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int BM = 16;
    localparam int CW = $clog2(BM + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          rd_val = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          busy, done, out_valid, out_last;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    int checks = 0, errors = 0;
    int cyc = 0, rd_cnt = 0, out_cnt = 0, done_cnt = 0;
    int done_cyc = 0, first_cyc = 0, last_cyc = 0, words_left = 0;
    int rb, ob, db, s;
    bit first_pend = 1'b0, spur = 1'b0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_val    (rd_val),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // FIFO read port: answers a request seen in one cycle during the next.
    task automatic fifo_model();
        logic saw;
        forever begin
            @(negedge clk);
            saw = rd_en;
            @(posedge clk);
            cyc++;
            #1;
            if (spur) begin
                rd_val  = 1'b1;
                rd_data = 8'hEE;
                spur    = 1'b0;
            end else if (saw && fifo_q.size() > 0) begin
                rd_val  = 1'b1;
                rd_data = fifo_q.pop_front();
            end else begin
                rd_val  = 1'b0;
                rd_data = DW'($urandom);
            end
        end
    endtask

    // Output stream monitor and scoreboard.
    task automatic monitor();
        logic          held = 1'b0;
        logic [DW-1:0] held_data = '0;
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rd_en) rd_cnt++;
            if (held && out_valid) check("hold_data", 32'(out_data), 32'(held_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("data", 32'(out_data), 32'(exp));
                    check("last", 32'(out_last), 32'(words_left == 1));
                end
                if (words_left > 0) words_left--;
                if (first_pend) begin
                    first_cyc  = cyc;
                    first_pend = 1'b0;
                end
                last_cyc = cyc;
                out_cnt++;
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
    endtask

    // Pulses start for one cycle; returns #1 after the sampling edge.
    task automatic do_start(input int len);
        @(posedge clk);
        #1;
        start      = 1'b1;
        burst_len  = CW'(len);
        words_left = len;
        first_pend = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        burst_len = CW'(7);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int base;
        bit got;
        base = done_cnt;
        got  = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(posedge clk);
            if (done_cnt != base) got = 1'b1;
        end
        check({tag, "_done"}, 32'(got), 32'd1);
        #1;
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_one_pulse"}, 32'(done_cnt - base), 32'd1);
    endtask

    task automatic run_hold(input logic [7:0] base, input int len);
        int r0, o0;
        out_ready = 1'b0;
        load(base, len);
        r0 = rd_cnt;
        o0 = out_cnt;
        do_start(len);
        repeat (10) @(posedge clk);
        #1;
        check("hold_reads", 32'(rd_cnt - r0), 32'd3);
        check("hold_rd_en", 32'(rd_en), 32'd0);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_head", 32'(out_data), 32'(exp_q[0]));
        out_ready = 1'b1;
        wait_done("hold", 60);
        check("hold_words", 32'(out_cnt - o0), 32'(len));
        check("hold_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            fifo_model();
            monitor();
        join_none

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Full FIFO, len=4, streaming
        out_ready = 1'b1;
        load(8'hA1, 4);
        rb = rd_cnt;
        do_start(4);
        s = cyc;
        check("t1_rd_en_lat", 32'(rd_en), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 40);
        check("t1_reads", 32'(rd_cnt - rb), 32'd4);
        check("t1_first_lat", 32'(first_cyc - s), 32'd2);
        check("t1_back2back", 32'(last_cyc - first_cyc), 32'd3);
        check("t1_done_lat", 32'(done_cyc - last_cyc), 32'd1);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Empty FIFO, data arrives later
        rb = rd_cnt;
        ob = out_cnt;
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hB2);
        do_start(2);
        repeat (5) @(posedge clk);
        fifo_q.push_back(8'hB1);
        fifo_q.push_back(8'hB2);
        wait_done("t2", 40);
        check("t2_retries", 32'(rd_cnt - rb > 2), 32'd1);
        check("t2_words", 32'(out_cnt - ob), 32'd2);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure
        run_hold(8'hC1, 3);
        run_hold(8'h31, 5);

        // Zero-length burst, then start during RUN ignored
        db = done_cnt;
        rb = rd_cnt;
        do_start(0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_rd_en", 32'(rd_en), 32'd0);
        @(posedge clk);
        #1;
        check("t4_done_drop", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_reads", 32'(rd_cnt - rb), 32'd0);
        check("t4_one_pulse", 32'(done_cnt - db), 32'd1);
        load(8'hD1, 2);
        rb = rd_cnt;
        ob = out_cnt;
        do_start(2);
        @(posedge clk);
        #1;
        start     = 1'b1;
        burst_len = CW'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4", 40);
        check("t4_words", 32'(out_cnt - ob), 32'd2);
        check("t4_reads", 32'(rd_cnt - rb), 32'd2);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-burst
        out_ready = 1'b0;
        load(8'hE1, 4);
        do_start(4);
        repeat (2) @(posedge clk);
        #3;
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_rd_en", 32'(rd_en), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_rd_en", 32'(rd_en), 32'd0);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_data", 32'(out_data), 32'd0);
        check("t5_last", 32'(out_last), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        fifo_q.delete();
        exp_q.delete();
        words_left = 0;
        #1;
        reset = 1'b1;
        spur  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_spur_valid", 32'(out_valid), 32'd0);
        check("t5_spur_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        load(8'hF1, 2);
        ob = out_cnt;
        do_start(2);
        wait_done("t5", 40);
        check("t5_words", 32'(out_cnt - ob), 32'd2);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
